// File: rtl/ram_phase_controller.sv
// Image RAM phase sequencer: UART receive -> processor run -> UART transmit -> done.
// Define PHASE_TIMEOUT_EN to add a processing watchdog that forces transmission after TIMEOUT_CYCLES.
module ram_phase_controller #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned NUM_BYTES      = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              p_wr,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_din,
  input  logic              p_finish,
  output logic              p_enable,
  output logic              r_wr,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_din,
  input  logic [DATA_W-1:0] r_dout,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              restart,
  output logic [1:0]        phase,
  output logic              rx_overrun,
  output logic              timeout
);

  // One extra bit so NUM_BYTES == 2**ADDR_W reaches its terminal count without wrapping.
  localparam int unsigned      CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    RECV     = 3'd0,
    PROC     = 3'd1,
    SEND_RD  = 3'd2,
    SEND_LAT = 3'd3,
    SEND_TX  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  wr_cnt, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_d;
  logic              p_enable_d;
  logic              tx_start_d;
  logic [DATA_W-1:0] tx_data_d;
  logic              rx_overrun_d;

`ifdef PHASE_TIMEOUT_EN
  localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] proc_cnt, proc_cnt_d;
  logic            timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  // State and registered outputs; reset aborts the frame immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RECV;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      p_enable   <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      state      <= state_d;
      wr_cnt     <= wr_cnt_d;
      rd_cnt     <= rd_cnt_d;
      p_enable   <= p_enable_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
      rx_overrun <= rx_overrun_d;
    end
  end

`ifdef PHASE_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      proc_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      proc_cnt <= proc_cnt_d;
      timeout  <= timeout_d;
    end
  end
`endif

  // Next-state, counters and handshake strobes.
  always_comb begin
    state_d      = state;
    wr_cnt_d     = wr_cnt;
    rd_cnt_d     = rd_cnt;
    tx_data_d    = tx_data;
    rx_overrun_d = rx_overrun | (rx_valid & (state != RECV));
`ifdef PHASE_TIMEOUT_EN
    proc_cnt_d   = '0;
    timeout_d    = timeout;
`endif

    case (state)
      RECV: begin
        if (rx_valid) begin
          if (wr_cnt == LAST) begin
            wr_cnt_d = '0;
            state_d  = PROC;
          end else begin
            wr_cnt_d = wr_cnt + CNT_W'(1);
          end
        end
      end
      PROC: begin
        if (p_finish) begin
          rd_cnt_d = '0;
          state_d  = SEND_RD;
        end
`ifdef PHASE_TIMEOUT_EN
        else if (proc_cnt == TO_LAST) begin
          timeout_d = 1'b1;
          rd_cnt_d  = '0;
          state_d   = SEND_RD;
        end else begin
          proc_cnt_d = proc_cnt + TO_W'(1);
        end
`endif
      end
      SEND_RD: begin
        state_d = SEND_LAT;
      end
      SEND_LAT: begin
        tx_data_d = r_dout;
        state_d   = SEND_TX;
      end
      SEND_TX: begin
        if (tx_ready) begin
          if (rd_cnt == LAST) begin
            state_d = DONE;
          end else begin
            rd_cnt_d = rd_cnt + CNT_W'(1);
            state_d  = SEND_RD;
          end
        end
      end
      DONE: begin
        if (restart) begin
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          state_d  = RECV;
        end
      end
      default: begin
        state_d = RECV;
      end
    endcase

    // Strobes are registered copies of the upcoming state.
    p_enable_d = (state_d == PROC);
    tx_start_d = (state_d == SEND_TX);
  end

  // RAM port ownership follows the current phase.
  always_comb begin
    r_wr   = 1'b0;
    r_addr = '0;
    r_din  = '0;
    case (state)
      RECV: begin
        r_wr   = rx_valid;
        r_addr = wr_cnt[ADDR_W-1:0];
        r_din  = rx_data;
      end
      PROC: begin
        r_wr   = p_wr;
        r_addr = p_addr;
        r_din  = p_din;
      end
      SEND_RD, SEND_LAT, SEND_TX: begin
        r_addr = rd_cnt[ADDR_W-1:0];
      end
      default: begin
        r_wr = 1'b0;
      end
    endcase
  end

  always_comb begin
    phase = 2'b11;
    case (state)
      RECV:                       phase = 2'b00;
      PROC:                       phase = 2'b01;
      SEND_RD, SEND_LAT, SEND_TX: phase = 2'b10;
      default:                    phase = 2'b11;
    endcase
  end

endmodule

// File: tb/tb_ram_phase_controller.sv
// Bench for ram_phase_controller with a 4-byte frame: directed cycle table, random frames, reset abort.
module tb_ram_phase_controller;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int          NB = 4;

  logic          clock, reset;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_din;
  logic          p_finish;
  logic          p_enable;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic [DW-1:0] r_dout;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          restart;
  logic [1:0]    phase;
  logic          rx_overrun;
  logic          timeout;

  int total = 0;
  int bad   = 0;

  ram_phase_controller #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_BYTES(NB), .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clock), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .p_wr(p_wr), .p_addr(p_addr), .p_din(p_din), .p_finish(p_finish),
    .p_enable(p_enable),
    .r_wr(r_wr), .r_addr(r_addr), .r_din(r_din), .r_dout(r_dout),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .restart(restart), .phase(phase), .rx_overrun(rx_overrun), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM behind the controller.
  logic [DW-1:0] ram [16];
  always @(posedge clock) begin
    if (r_wr) ram[r_addr[3:0]] <= r_din;
    r_dout <= ram[r_addr[3:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic cyc_in(input logic rxv, input logic [7:0] rxd, input logic pwr,
                        input logic [15:0] pa, input logic [7:0] pd, input logic pfin,
                        input logic txr, input logic rs);
    @(negedge clock);
    rx_valid = rxv; rx_data = rxd; p_wr = pwr; p_addr = pa; p_din = pd;
    p_finish = pfin; tx_ready = txr; restart = rs;
    #1;
  endtask

  task automatic idle(input logic txr);
    cyc_in(1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0, txr, 1'b0);
  endtask

  // Transmit phase scoreboard: mode 0 always ready, 1 stall byte 1 for 10 cycles, 2 random ready.
  task automatic send_phase(input logic [7:0] eb [4], input int mode);
    int got, cyc, last_acc, stall;
    logic prev_stall;
    logic [7:0] prev_data;
    got = 0; cyc = 0; last_acc = -100; stall = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (got < NB && cyc < 400) begin
      @(negedge clock);
      rx_valid = 1'b0; rx_data = 8'h00; p_wr = 1'b0; p_addr = 16'h0; p_din = 8'h00;
      p_finish = 1'b0; restart = 1'b0;
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = !(tx_start && got == 1 && stall < 10);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("send_phase", 32'(phase), 2);
      if (prev_stall) begin
        chk("hold_tx_start", 32'(tx_start), 1);
        chk("hold_tx_data", 32'(tx_data), 32'(prev_data));
      end
      prev_stall = tx_start && !tx_ready;
      prev_data  = tx_data;
      if (tx_start && !tx_ready) stall++;
      if (tx_start && tx_ready) begin
        chk("tx_byte", 32'(tx_data), 32'(eb[got]));
        if (got > 0) begin
          if (mode == 0) chk("tx_gap_exact", 32'(cyc - last_acc), 3);
          else           chk("tx_gap_min", 32'(cyc - last_acc >= 3), 1);
        end
        last_acc = cyc;
        got++;
      end
      cyc++;
    end
    if (got != NB) chk("send_budget", 32'(got), 32'(NB));
    idle(1'b0);
    chk("done_phase", 32'(phase), 3);
    chk("done_tx_start", 32'(tx_start), 0);
    if (mode == 1) chk("stall_cycles", 32'(stall), 10);
  endtask

  typedef struct {
    logic rxv; logic [7:0] rxd; logic pwr; logic [15:0] pa; logic [7:0] pd;
    logic pfin; logic txr; logic rs;
    logic [1:0] ph; logic pen; logic ts; logic [7:0] td; logic rwr;
    logic [15:0] ra; logic [7:0] rd; logic ovr;
  } vec_t;

  vec_t vt [22];

  initial begin
    logic [7:0] mem [4];
    int pc;

    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; p_wr = 1'b0; p_addr = 16'h0;
    p_din = 8'h00; p_finish = 1'b0; tx_ready = 1'b0; restart = 1'b0;

    //       rxv   rxd    pwr   pa      pd     pfin  txr   rs   | ph    pen   ts    td     rwr   ra      rd     ovr
    vt[0]  = '{1'b1,8'hA1,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd0,1'b0,1'b0,8'h00,1'b1,16'h0,8'hA1,1'b0};
    vt[1]  = '{1'b1,8'hB2,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd0,1'b0,1'b0,8'h00,1'b1,16'h1,8'hB2,1'b0};
    vt[2]  = '{1'b1,8'hC3,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd0,1'b0,1'b0,8'h00,1'b1,16'h2,8'hC3,1'b0};
    vt[3]  = '{1'b1,8'hD4,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd0,1'b0,1'b0,8'h00,1'b1,16'h3,8'hD4,1'b0};
    vt[4]  = '{1'b0,8'h00,1'b1,16'h2,8'h55,1'b0,1'b1,1'b0, 2'd1,1'b1,1'b0,8'h00,1'b1,16'h2,8'h55,1'b0};
    vt[5]  = '{1'b1,8'hEE,1'b0,16'h0,8'h00,1'b1,1'b1,1'b0, 2'd1,1'b1,1'b0,8'h00,1'b0,16'h0,8'h00,1'b0};
    vt[6]  = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b0,8'h00,1'b0,16'h0,8'h00,1'b1};
    vt[7]  = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b0,8'h00,1'b0,16'h0,8'h00,1'b1};
    vt[8]  = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b1,8'hA1,1'b0,16'h0,8'h00,1'b1};
    vt[9]  = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b1, 2'd2,1'b0,1'b0,8'hA1,1'b0,16'h1,8'h00,1'b1};
    vt[10] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b0,8'hA1,1'b0,16'h1,8'h00,1'b1};
    vt[11] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b1,8'hB2,1'b0,16'h1,8'h00,1'b1};
    vt[12] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b0,8'hB2,1'b0,16'h2,8'h00,1'b1};
    vt[13] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b0,8'hB2,1'b0,16'h2,8'h00,1'b1};
    vt[14] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b1,8'h55,1'b0,16'h2,8'h00,1'b1};
    vt[15] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b0,8'h55,1'b0,16'h3,8'h00,1'b1};
    vt[16] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b0,8'h55,1'b0,16'h3,8'h00,1'b1};
    vt[17] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd2,1'b0,1'b1,8'hD4,1'b0,16'h3,8'h00,1'b1};
    vt[18] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b0, 2'd3,1'b0,1'b0,8'hD4,1'b0,16'h0,8'h00,1'b1};
    vt[19] = '{1'b0,8'h00,1'b0,16'h0,8'h00,1'b0,1'b1,1'b1, 2'd3,1'b0,1'b0,8'hD4,1'b0,16'h0,8'h00,1'b1};
    vt[20] = '{1'b1,8'h11,1'b0,16'h0,8'h00,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,8'hD4,1'b1,16'h0,8'h11,1'b1};
    vt[21] = '{1'b1,8'h22,1'b0,16'h0,8'h00,1'b0,1'b0,1'b0, 2'd0,1'b0,1'b0,8'hD4,1'b1,16'h1,8'h22,1'b1};

    // Reset state.
    @(negedge clock); #1;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_p_enable", 32'(p_enable), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rx_overrun", 32'(rx_overrun), 0);
    chk("rst_timeout", 32'(timeout), 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed frame, one row per clock.
    for (int i = 0; i < 22; i++) begin
      cyc_in(vt[i].rxv, vt[i].rxd, vt[i].pwr, vt[i].pa, vt[i].pd, vt[i].pfin, vt[i].txr, vt[i].rs);
      chk("vec_phase", 32'(phase), 32'(vt[i].ph));
      chk("vec_p_enable", 32'(p_enable), 32'(vt[i].pen));
      chk("vec_tx_start", 32'(tx_start), 32'(vt[i].ts));
      chk("vec_tx_data", 32'(tx_data), 32'(vt[i].td));
      chk("vec_r_wr", 32'(r_wr), 32'(vt[i].rwr));
      chk("vec_r_addr", 32'(r_addr), 32'(vt[i].ra));
      chk("vec_r_din", 32'(r_din), 32'(vt[i].rd));
      chk("vec_rx_overrun", 32'(rx_overrun), 32'(vt[i].ovr));
      chk("vec_timeout", 32'(timeout), 0);
    end

    // Finish the second frame; long processing, then back-pressure on byte 1.
    cyc_in(1'b1, 8'h33, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("f2_addr2", 32'(r_addr), 2);
    cyc_in(1'b1, 8'h44, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("f2_addr3", 32'(r_addr), 3);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
`ifdef PHASE_TIMEOUT_EN
    pc = 0;
    idle(1'b0);
    while (phase == 2'd1 && pc < 60) begin
      pc++;
      idle(1'b0);
    end
    chk("proc_cycles_to_timeout", 32'(pc), 20);
    chk("timeout_flag", 32'(timeout), 1);
    chk("timeout_p_enable", 32'(p_enable), 0);
    chk("timeout_phase", 32'(phase), 2);
`else
    pc = 0;
    repeat (30) begin
      idle(1'b0);
      if (phase == 2'd1) pc++;
    end
    chk("proc_wait_cycles", 32'(pc), 30);
    chk("proc_wait_p_enable", 32'(p_enable), 1);
    chk("proc_no_timeout", 32'(timeout), 0);
    cyc_in(1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif
    send_phase(mem, 1);
    cyc_in(1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("restart_phase", 32'(phase), 0);

    // Random frames against a frame-level model: received bytes overlaid by processor writes.
    for (int f = 0; f < 6; f++) begin
      int g, nw, a;
      logic [7:0] d;
      for (int b = 0; b < NB; b++) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          idle(1'b0);
          chk("recv_gap_phase", 32'(phase), 0);
          chk("recv_gap_r_wr", 32'(r_wr), 0);
        end
        mem[b] = 8'($urandom);
        cyc_in(1'b1, mem[b], 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("recv_r_wr", 32'(r_wr), 1);
        chk("recv_r_addr", 32'(r_addr), 32'(b));
      end
      idle(1'b0);
      chk("proc_entry_phase", 32'(phase), 1);
      chk("proc_entry_p_enable", 32'(p_enable), 1);
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        a = $urandom_range(0, NB - 1);
        d = 8'($urandom);
        mem[a] = d;
        cyc_in(1'b0, 8'h00, 1'b1, 16'(a), d, 1'b0, 1'b0, 1'b0);
        chk("proc_r_addr", 32'(r_addr), 32'(a));
        chk("proc_r_din", 32'(r_din), 32'(d));
      end
      if ($urandom_range(0, 1) == 1) begin
        cyc_in(1'b1, 8'hFF, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("stray_rx_r_wr", 32'(r_wr), 0);
      end
      cyc_in(1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
      send_phase(mem, f % 3);
      chk("overrun_sticky", 32'(rx_overrun), 1);
      cyc_in(1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      chk("rand_restart_phase", 32'(phase), 0);
    end

    // Reset while a byte is being offered aborts at once.
    for (int b = 0; b < NB; b++) cyc_in(1'b1, 8'(b), 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc_in(1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    pc = 0;
    idle(1'b0);
    while (!tx_start && pc < 20) begin
      pc++;
      idle(1'b0);
    end
    chk("abort_tx_start_seen", 32'(tx_start), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_tx_start", 32'(tx_start), 0);
    chk("abort_phase", 32'(phase), 0);
    chk("abort_p_enable", 32'(p_enable), 0);
    chk("abort_rx_overrun", 32'(rx_overrun), 0);
    chk("abort_timeout", 32'(timeout), 0);
    @(negedge clock);
    reset = 1'b0;
    cyc_in(1'b1, 8'h5A, 1'b0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("post_abort_addr", 32'(r_addr), 0);
    chk("post_abort_r_wr", 32'(r_wr), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
